// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer that shares one 256-bit
// line memory between the instruction-cache and data-cache miss ports.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [LINE_W-1:0] p0_wdata_i,
    output logic              p0_ack_o,
    output logic [LINE_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [LINE_W-1:0] p1_wdata_i,
    output logic              p1_ack_o,
    output logic [LINE_W-1:0] p1_rdata_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    logic   grant;
    logic   last_grant;
    logic   any_req;
    logic   pick;
    logic   resp;

    assign any_req = p0_req_i | p1_req_i;
    // Port 1 wins when alone, or on contention when port 0 was served last.
    assign pick    = p1_req_i & (~p0_req_i | ~last_grant);
    assign resp    = (state == RESP);

    assign p0_rdata_o = (resp && !grant) ? mem_data_i : '0;
    assign p1_rdata_o = (resp &&  grant) ? mem_data_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            p0_ack_o     <= 1'b0;
            p1_ack_o     <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            mem_enable_o <= 1'b0;
            p0_ack_o     <= 1'b0;
            p1_ack_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant        <= pick;
                        mem_write_o  <= pick ? p1_we_i : p0_we_i;
                        mem_addr_o   <= pick ? p1_addr_i : p0_addr_i;
                        mem_data_o   <= pick ? p1_wdata_i : p0_wdata_i;
                        mem_enable_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        p0_ack_o <= ~grant;
                        p1_ack_o <= grant;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared 256-bit line memory (512 lines, 16 KB, fixed 10-cycle access). It sits between the instruction-cache miss port (port 0) and the data-cache miss/write-back port (port 1) and the single memory port. It grants one requester at a time with round-robin fairness. It drives the memory with a one-cycle enable pulse and holds address, data and write flag stable until ack. It returns read data and a one-cycle ack to the granted requester.

## Interface
- ADDR_W, 32, requester/memory byte-address width
- LINE_W, 256, cache-line width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- p0_req_i / p1_req_i  in  1  request; held high until that port's ack
- p0_we_i / p1_we_i  in  1  1 = line write, 0 = line read; stable while req high
- p0_addr_i / p1_addr_i  in  ADDR_W  line byte address; stable while req high
- p0_wdata_i / p1_wdata_i  in  LINE_W  write line; stable while req high
- p0_ack_o / p1_ack_o  out  1  one-cycle completion pulse
- p0_rdata_o / p1_rdata_o  out  LINE_W  read line; valid in that port's ack cycle; 0 otherwise
- mem_enable_o  out  1  one-cycle start pulse to memory
- mem_write_o  out  1  write flag to memory
- mem_addr_o  out  ADDR_W  address to memory
- mem_data_o  out  LINE_W  write data to memory
- mem_ack_i  in  1  memory completion, one cycle
- mem_data_i  in  LINE_W  memory read line; valid from the cycle after mem_ack_i
- busy_o  out  1  high in every non-IDLE state

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, select the winner.
  - If only one port requests, it wins.
  - If both request, the port not granted last wins.
  - Latch grant, addr, wdata and we into mem_addr_o / mem_data_o / mem_write_o. Go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: mem_enable_o = 1 for exactly this cycle. Go to WAIT.
- WAIT: mem_enable_o = 0 and mem_* held. On mem_ack_i go to RESP; otherwise stay.
- RESP: ack_o of the granted port = 1, and its rdata_o = mem_data_i. Update last_grant to the granted port. Go to IDLE.
  - For writes, rdata_o content is don't-care but is still driven from mem_data_i.
- In any state, the non-granted port's ack_o = 0 and its rdata_o = 0.
- Requests arriving at a non-granted port are held off. They are evaluated only in IDLE.
- mem_ack_i outside WAIT is ignored.
- mem_addr_o, mem_data_o and mem_write_o change only on the IDLE→ISSUE edge. They hold their values through IDLE afterwards.
- Reset values:
  - state IDLE, last_grant = 1 (port 0 wins the first contention)
  - mem_enable_o, mem_write_o, mem_addr_o, mem_data_o all 0
  - both ack_o 0, both rdata_o 0, busy_o 0
- Reset mid-transaction: return to IDLE next edge and drop the transaction without issuing ack. rst_i is shared with the memory (inverted at its input), so both restart clean.

## Timing
- Cycle 0: req high, arbiter in IDLE; the request is latched at the end of cycle 0.
- Cycle 1 is ISSUE (mem_enable_o high), and the memory enters its wait state at the end of cycle 1.
- mem_ack_i is high in cycle 11, and memory read data updates at the end of cycle 11.
- Cycle 12 is RESP: port ack_o high with rdata_o valid. Total request-to-ack latency is 12 cycles.
- The requester drops req in the cycle after its ack. The arbiter is in RESP during the ack cycle and does not resample, so there is no duplicate grant.
- Back-to-back: the earliest next grant is latched at the end of cycle 13, when the memory is already idle.
- busy_o is high in cycles 1–12.

## Test plan
- Single read, port 0: memory line 5 preloaded with pattern A. Assert p0_req_i, we=0, addr=0xA0.
  - Required: mem_enable_o pulses in cycle 1; p0_ack_o in cycle 12 with p0_rdata_o = A; p1 outputs stay 0.
- Single write then read, port 1: write pattern B to addr 0x1E0, then read 0x1E0.
  - Required: mem_write_o = 1 during the first transaction; the second ack returns B.
- Simultaneous requests after reset: p0 and p1 both raised in cycle 0.
  - Required: p0 acks at cycle 12 and p1 acks at cycle 25; mem_addr_o is stable from cycle 1 to 12 and from 14 to 25.
- Fairness: both ports held continuously with re-requests.
  - Required: the ack sequence alternates p0, p1, p0, p1, with no port acked twice in a row.
- Mid-transaction reset: assert rst_i in cycle 6 of a port 0 read.
  - Required: the next cycle is IDLE and busy_o = 0; no ack is issued; a fresh request completes normally in 12 cycles.
- Spurious mem_ack_i in IDLE plus a request change while WAIT.
  - Required: the spurious ack is ignored; the other port's late request is served only after the current RESP.
